// File: rtl/slurm16_mem_pkg.sv
// slurm16_mem_pkg: constants shared by the slurm16 memory arbiter slice.
//   NUM_MASTERS_DEF      default number of bus masters
//   MASTER_*             board-level master slot assignment
//   BITS_DEF / ADDRESS_BITS_DEF / MASK_BITS   bus widths
package slurm16_mem_pkg;

   localparam int NUM_MASTERS_DEF  = 4;

   localparam int MASTER_CPU   = 0;
   localparam int MASTER_GFX   = 1;
   localparam int MASTER_AUDIO = 2;
   localparam int MASTER_SPARE = 3;

   localparam int BITS_DEF         = 16;
   localparam int ADDRESS_BITS_DEF = 16;
   localparam int MASK_BITS        = 2;

endpackage

// File: rtl/slurm16_rr_select.sv
// slurm16_rr_select: combinational rotating-priority selector.
//   req      in   N   request vector
//   start    in   IW  index searched first; search wraps modulo N
//   gnt      out  N   one-hot grant (all zero when no request)
//   gnt_idx  out  IW  encoded index of gnt (0 when no request)
module slurm16_rr_select
   import slurm16_mem_pkg::*;
#(
   parameter int N  = NUM_MASTERS_DEF,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] start,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_idx
);

   always_comb begin
      int   idx;
      logic found;
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      idx     = 0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(start) + k) % N;
         if (!found && req[idx]) begin
            found    = 1'b1;
            gnt[idx] = 1'b1;
            gnt_idx  = IW'(idx);
         end
      end
   end

endmodule

// File: rtl/slurm16_memory_arbiter.sv
// slurm16_memory_arbiter: round-robin arbiter with bounded burst hold for the
// single-ported slurm16 main memory (one-cycle read latency).
//   CLK, RSTb                 clock, async active-low reset
//   m_address/m_data_out/m_valid/m_wr/m_wr_mask   flattened master requests
//   m_ready                   one-hot grant, same cycle as the request
//   m_rvalid                  read data valid, one cycle after the grant
//   m_data_in                 memory read data broadcast to all masters
//   mem_*                     memory port driven from the granted master
module slurm16_memory_arbiter
   import slurm16_mem_pkg::*;
#(
   parameter int NUM_MASTERS  = NUM_MASTERS_DEF,
   parameter int BITS         = BITS_DEF,
   parameter int ADDRESS_BITS = ADDRESS_BITS_DEF,
   parameter int MAX_BURST    = 4
) (
   input  logic                                 CLK,
   input  logic                                 RSTb,
   input  logic [NUM_MASTERS*ADDRESS_BITS-1:0]  m_address,
   input  logic [NUM_MASTERS*BITS-1:0]          m_data_out,
   input  logic [NUM_MASTERS-1:0]               m_valid,
   input  logic [NUM_MASTERS-1:0]               m_wr,
   input  logic [NUM_MASTERS*MASK_BITS-1:0]     m_wr_mask,
   output logic [NUM_MASTERS-1:0]               m_ready,
   output logic [NUM_MASTERS-1:0]               m_rvalid,
   output logic [BITS-1:0]                      m_data_in,
   output logic [ADDRESS_BITS-1:0]              mem_address,
   output logic [BITS-1:0]                      mem_data_out,
   output logic                                 mem_en,
   output logic                                 mem_wr,
   output logic [MASK_BITS-1:0]                 mem_wr_mask,
   input  logic [BITS-1:0]                      mem_data_in
);

   localparam int IW  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
   localparam int BCW = $clog2(MAX_BURST) + 1;

   logic [IW-1:0]          owner;
   logic [BCW-1:0]         burst_cnt;
   logic [NUM_MASTERS-1:0] rvalid_q;

   logic [IW-1:0]          start, rr_idx, sel_idx;
   logic [NUM_MASTERS-1:0] rr_gnt, gnt;
   logic                   hold, any_gnt;

   // Search begins just past the last owner; the owner itself is tried last,
   // which is what lets a lone master keep streaming past the burst limit.
   assign start = (owner == IW'(NUM_MASTERS - 1)) ? '0 : owner + 1'b1;

   slurm16_rr_select #(.N(NUM_MASTERS), .IW(IW)) u_rr_select (
      .req     (m_valid),
      .start   (start),
      .gnt     (rr_gnt),
      .gnt_idx (rr_idx)
   );

   // burst_cnt is 0 after an idle cycle, so non-zero means "owner was
   // granted last cycle".
   assign hold = m_valid[owner] && (burst_cnt != '0) && (burst_cnt < BCW'(MAX_BURST));

   always_comb begin
      gnt     = rr_gnt;
      sel_idx = rr_idx;
      if (hold) begin
         gnt        = '0;
         gnt[owner] = 1'b1;
         sel_idx    = owner;
      end
   end

   assign any_gnt = |gnt;
   assign m_ready = gnt;

   always_comb begin
      mem_address  = '0;
      mem_data_out = '0;
      mem_wr       = 1'b0;
      mem_wr_mask  = '0;
      mem_en       = any_gnt;
      if (any_gnt) begin
         mem_address  = m_address[int'(sel_idx)*ADDRESS_BITS +: ADDRESS_BITS];
         mem_data_out = m_data_out[int'(sel_idx)*BITS +: BITS];
         mem_wr       = m_wr[sel_idx];
         mem_wr_mask  = m_wr_mask[int'(sel_idx)*MASK_BITS +: MASK_BITS];
      end
   end

   assign m_rvalid  = rvalid_q;
   assign m_data_in = mem_data_in;

   always_ff @(posedge CLK or negedge RSTb) begin
      if (!RSTb) begin
         owner     <= IW'(NUM_MASTERS - 1);
         burst_cnt <= '0;
         rvalid_q  <= '0;
      end else begin
         rvalid_q <= (any_gnt && !mem_wr) ? gnt : '0;
         if (any_gnt) begin
            owner <= sel_idx;
            if ((burst_cnt != '0) && (sel_idx == owner))
               burst_cnt <= (burst_cnt < BCW'(MAX_BURST)) ? burst_cnt + 1'b1 : burst_cnt;
            else
               burst_cnt <= BCW'(1);
         end else begin
            burst_cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_slurm16_memory_arbiter.sv
module tb_slurm16_memory_arbiter;

   logic        CLK = 1'b0;
   logic        RSTb;
   logic [63:0] m_address;
   logic [63:0] m_data_out;
   logic [3:0]  m_valid;
   logic [3:0]  m_wr;
   logic [7:0]  m_wr_mask;
   logic [15:0] mem_data_in;

   logic [3:0]  m_ready, m_rvalid;
   logic [15:0] m_data_in, mem_address, mem_data_out;
   logic        mem_en, mem_wr;
   logic [1:0]  mem_wr_mask;

   logic [3:0]  m_ready1, m_rvalid1;
   logic [15:0] m_data_in1, mem_address1, mem_data_out1;
   logic        mem_en1, mem_wr1;
   logic [1:0]  mem_wr_mask1;

   always #5 CLK = ~CLK;

   slurm16_memory_arbiter #(.MAX_BURST(4)) dut (
      .CLK(CLK), .RSTb(RSTb), .m_address(m_address), .m_data_out(m_data_out),
      .m_valid(m_valid), .m_wr(m_wr), .m_wr_mask(m_wr_mask), .m_ready(m_ready),
      .m_rvalid(m_rvalid), .m_data_in(m_data_in), .mem_address(mem_address),
      .mem_data_out(mem_data_out), .mem_en(mem_en), .mem_wr(mem_wr),
      .mem_wr_mask(mem_wr_mask), .mem_data_in(mem_data_in));

   slurm16_memory_arbiter #(.MAX_BURST(1)) dut1 (
      .CLK(CLK), .RSTb(RSTb), .m_address(m_address), .m_data_out(m_data_out),
      .m_valid(m_valid), .m_wr(m_wr), .m_wr_mask(m_wr_mask), .m_ready(m_ready1),
      .m_rvalid(m_rvalid1), .m_data_in(m_data_in1), .mem_address(mem_address1),
      .mem_data_out(mem_data_out1), .mem_en(mem_en1), .mem_wr(mem_wr1),
      .mem_wr_mask(mem_wr_mask1), .mem_data_in(mem_data_in));

   typedef struct packed {
      logic [3:0]  rdy;
      logic [15:0] addr;
      logic [15:0] dout;
      logic        wr;
      logic [1:0]  mk;
   } gexp_t;

   typedef struct packed {
      logic [3:0]  rv;
      logic [15:0] data;
   } rexp_t;

   gexp_t gq0[$], gq1[$];
   rexp_t rq0[$], rq1[$];
   int    checks = 0;
   int    errors = 0;
   bit    chk0 = 0, chk1 = 0;

   logic [15:0] addr_tab [4] = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic set_m(input int i, input logic [15:0] a, input logic [15:0] d,
                        input logic w, input logic [1:0] mk);
      m_address[i*16 +: 16]  = a;
      m_data_out[i*16 +: 16] = d;
      m_wr[i]                = w;
      m_wr_mask[i*2 +: 2]    = mk;
   endtask

   function automatic logic [3:0] oh(input int i);
      logic [3:0] one;
      one = 4'b0001;
      return one << i;
   endfunction

   // expected grant on dut (MAX_BURST=4); reads also expect a return next cycle
   task automatic exp0(input int i, input logic [15:0] a, input logic [15:0] d,
                       input logic w, input logic [1:0] mk, input logic [15:0] rdata,
                       input bit want_rv);
      gq0.push_back('{rdy: oh(i), addr: a, dout: d, wr: w, mk: mk});
      if (!w && want_rv) rq0.push_back('{rv: oh(i), data: rdata});
   endtask

   task automatic exp1(input int i, input logic [15:0] rdata);
      gq1.push_back('{rdy: oh(i), addr: addr_tab[i], dout: 16'h0, wr: 1'b0, mk: 2'b00});
      rq1.push_back('{rv: oh(i), data: rdata});
   endtask

   // monitor for dut
   always @(negedge CLK) if (chk0) begin
      gexp_t g; rexp_t r;
      checks++;
      if (|m_ready) begin
         if (gq0.size() == 0) begin
            errors++;
            $display("FAIL grant0: unexpected m_ready=%b addr=%h", m_ready, mem_address);
         end else begin
            g = gq0.pop_front();
            if (m_ready !== g.rdy || mem_address !== g.addr || mem_data_out !== g.dout ||
                mem_wr !== g.wr || mem_wr_mask !== g.mk || mem_en !== 1'b1) begin
               errors++;
               $display("FAIL grant0: got rdy=%b addr=%h dout=%h wr=%b mk=%b en=%b expected rdy=%b addr=%h dout=%h wr=%b mk=%b en=1",
                        m_ready, mem_address, mem_data_out, mem_wr, mem_wr_mask, mem_en,
                        g.rdy, g.addr, g.dout, g.wr, g.mk);
            end
         end
      end else if (mem_en !== 1'b0 || mem_address !== 16'h0 || mem_data_out !== 16'h0 ||
                   mem_wr !== 1'b0 || mem_wr_mask !== 2'b00) begin
         errors++;
         $display("FAIL idle0: got en=%b addr=%h dout=%h wr=%b mk=%b expected all zero",
                  mem_en, mem_address, mem_data_out, mem_wr, mem_wr_mask);
      end
      if (|m_rvalid) begin
         checks++;
         if (rq0.size() == 0) begin
            errors++;
            $display("FAIL rvalid0: unexpected m_rvalid=%b", m_rvalid);
         end else begin
            r = rq0.pop_front();
            if (m_rvalid !== r.rv || m_data_in !== r.data) begin
               errors++;
               $display("FAIL rvalid0: got rv=%b data=%h expected rv=%b data=%h",
                        m_rvalid, m_data_in, r.rv, r.data);
            end
         end
      end
   end

   // monitor for dut1
   always @(negedge CLK) if (chk1) begin
      gexp_t g; rexp_t r;
      if (|m_ready1) begin
         checks++;
         if (gq1.size() == 0) begin
            errors++;
            $display("FAIL grant1: unexpected m_ready=%b", m_ready1);
         end else begin
            g = gq1.pop_front();
            if (m_ready1 !== g.rdy || mem_address1 !== g.addr || mem_en1 !== 1'b1) begin
               errors++;
               $display("FAIL grant1: got rdy=%b addr=%h expected rdy=%b addr=%h",
                        m_ready1, mem_address1, g.rdy, g.addr);
            end
         end
      end
      if (|m_rvalid1) begin
         checks++;
         if (rq1.size() == 0) begin
            errors++;
            $display("FAIL rvalid1: unexpected m_rvalid=%b", m_rvalid1);
         end else begin
            r = rq1.pop_front();
            if (m_rvalid1 !== r.rv || m_data_in1 !== r.data) begin
               errors++;
               $display("FAIL rvalid1: got rv=%b data=%h expected rv=%b data=%h",
                        m_rvalid1, m_data_in1, r.rv, r.data);
            end
         end
      end
   end

   int seq2 [10] = '{0, 0, 0, 0, 2, 2, 2, 2, 0, 0};
   int seq5 [6]  = '{0, 1, 2, 3, 0, 1};

   initial begin
      RSTb = 1'b0;
      m_address = '0; m_data_out = '0; m_valid = '0; m_wr = '0; m_wr_mask = '0;
      mem_data_in = '0;
      tick(); tick();

      // reset state
      chk("rst_ready",  {28'h0, m_ready},  32'h0);
      chk("rst_rvalid", {28'h0, m_rvalid}, 32'h0);
      chk("rst_mem_en", {31'h0, mem_en},   32'h0);
      chk("rst_addr",   {16'h0, mem_address}, 32'h0);
      chk("rst_data_in", {16'h0, m_data_in}, 32'h0);
      chk("rst_ready1", {28'h0, m_ready1}, 32'h0);
      RSTb = 1'b1;
      chk0 = 1;

      // single read by master 0
      set_m(0, 16'h1234, 16'h0, 1'b0, 2'b00);
      m_valid = 4'b0001;
      exp0(0, 16'h1234, 16'h0, 1'b0, 2'b00, 16'hBEEF, 1);
      tick();
      m_valid = 4'b0000;
      mem_data_in = 16'hBEEF;
      tick();

      // contention from reset: masters 0 and 2
      RSTb = 1'b0; tick(); RSTb = 1'b1;
      mem_data_in = 16'h5A5A;
      set_m(0, addr_tab[0], 16'h0, 1'b0, 2'b00);
      set_m(2, addr_tab[2], 16'h0, 1'b0, 2'b00);
      m_valid = 4'b0101;
      for (int c = 0; c < 10; c++) begin
         exp0(seq2[c], addr_tab[seq2[c]], 16'h0, 1'b0, 2'b00, 16'h5A5A, 1);
         tick();
      end
      m_valid = 4'b0000;
      tick();

      // burst release: master 1 alone for 6 cycles, master 3 joins at cycle 6
      set_m(1, addr_tab[1], 16'h0, 1'b0, 2'b00);
      set_m(3, addr_tab[3], 16'h0, 1'b0, 2'b00);
      m_valid = 4'b0010;
      for (int c = 0; c < 6; c++) begin
         exp0(1, addr_tab[1], 16'h0, 1'b0, 2'b00, 16'h5A5A, 1);
         tick();
      end
      m_valid = 4'b1010;
      exp0(3, addr_tab[3], 16'h0, 1'b0, 2'b00, 16'h5A5A, 1);
      tick();
      m_valid = 4'b0000;
      tick();

      // masked write by master 2: no read return afterwards
      set_m(2, 16'h8000, 16'hAA55, 1'b1, 2'b10);
      m_valid = 4'b0100;
      exp0(2, 16'h8000, 16'hAA55, 1'b1, 2'b10, 16'h0, 0);
      tick();
      m_valid = 4'b0000;
      tick();
      set_m(2, addr_tab[2], 16'h0, 1'b0, 2'b00);

      // pure round-robin on the MAX_BURST=1 instance
      chk0 = 0;
      RSTb = 1'b0; tick(); RSTb = 1'b1;
      chk1 = 1;
      m_valid = 4'b1111;
      for (int c = 0; c < 6; c++) begin
         exp1(seq5[c], 16'h5A5A);
         tick();
      end
      m_valid = 4'b0000;
      tick();
      chk1 = 0;

      // reset the cycle after a read grant kills its return; owner restarts at 3
      chk0 = 1;
      m_valid = 4'b0010;
      exp0(1, addr_tab[1], 16'h0, 1'b0, 2'b00, 16'h5A5A, 0);
      tick();
      m_valid = 4'b0000;
      RSTb = 1'b0;
      #1;
      chk("rst_mid_rvalid", {28'h0, m_rvalid}, 32'h0);
      tick();
      RSTb = 1'b1;
      m_valid = 4'b1010;
      exp0(1, addr_tab[1], 16'h0, 1'b0, 2'b00, 16'h5A5A, 1);
      tick();
      m_valid = 4'b0000;
      tick(); tick();
      chk0 = 0;

      chk("drain_dut",  32'(gq0.size() + rq0.size()), 32'h0);
      chk("drain_dut1", 32'(gq1.size() + rq1.size()), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/slurm16_memory_arbiter.md
# slurm16_memory_arbiter

Arbitrates single-ported 16-bit main memory between up to NUM_MASTERS bus masters: the slurm16 CPU memory interface and DMA masters such as graphics and audio. Sits directly downstream of the CPU's memory_address / memory_valid / memory_wr / memory_wr_mask outputs and produces the memory_ready grant those outputs wait on. Arbitration is round-robin with a bounded burst hold, so back-to-back instruction fetches stay efficient without starving other masters. Memory is synchronous with one-cycle read latency.

## Interface
- NUM_MASTERS, 4, number of masters; master 0 is the CPU by board convention, with no priority privilege.
- BITS, 16, data width.
- ADDRESS_BITS, 16, address width.
- MAX_BURST, 4, max consecutive grants to one master while others wait; 1 = pure round-robin.

Ports (all per-master buses are flattened, master i in slice i):
- CLK  in  1  clock.
- RSTb  in  1  reset; asynchronous, active-low.
- m_address  in  NUM_MASTERS*ADDRESS_BITS  request address.
- m_data_out  in  NUM_MASTERS*BITS  write data.
- m_valid  in  NUM_MASTERS  request pending.
- m_wr  in  NUM_MASTERS  1 = write, 0 = read.
- m_wr_mask  in  NUM_MASTERS*2  byte enables {hi, lo}; used only on writes.
- m_ready  out  NUM_MASTERS  grant; request accepted this cycle.
- m_rvalid  out  NUM_MASTERS  read data valid on m_data_in this cycle.
- m_data_in  out  BITS  read data, broadcast to all masters.
- mem_address  out  ADDRESS_BITS  to memory.
- mem_data_out  out  BITS  write data to memory.
- mem_en  out  1  memory access this cycle.
- mem_wr  out  1  memory write.
- mem_wr_mask  out  2  byte enables.
- mem_data_in  in  BITS  memory read data, one cycle after the address.

## Operation
- Registered state:
  - owner: index of the last granted master.
  - burst_cnt: consecutive grants to owner, width clog2(MAX_BURST)+1.
  - rvalid_q: NUM_MASTERS bits.
- Grant selection is combinational from m_valid and registered state. At most one m_ready bit is high.
  - Hold: if m_valid[owner] and the previous cycle granted owner and burst_cnt < MAX_BURST, grant owner again.
  - Rotate: otherwise search m_valid from owner+1 upward, wrapping modulo NUM_MASTERS, including owner itself last. Grant the first set bit.
  - If no m_valid bit is set, no grant.
- Burst counting:
  - On a grant to the same master as the previous cycle's grant, burst_cnt increments, saturating at MAX_BURST.
  - On a grant to a different master, or after a cycle with no grant, burst_cnt = 1.
  - owner updates on every grant and keeps its value on idle cycles.
- Burst-limit exception: if burst_cnt reaches MAX_BURST and no other master is valid, owner is granted again (search wraps to it) and burst_cnt stays at MAX_BURST.
- Memory port muxing:
  - mem_address, mem_data_out, mem_wr and mem_wr_mask are muxed from the granted master.
  - mem_en = any grant.
  - With no grant, all memory outputs are 0.
- Read return:
  - A granted read sets rvalid_q[i] for the next cycle.
  - m_rvalid = rvalid_q.
  - m_data_in = mem_data_in passthrough, unregistered.
  - Writes never raise rvalid.
- Masters hold address, data and control stable while m_valid=1 and m_ready=0. A master may drop m_valid at any time without penalty.

## Timing
- Reset values (asynchronous on RSTb low):
  - owner = NUM_MASTERS-1, so master 0 wins the first contention.
  - burst_cnt = 0; rvalid_q = 0.
  - Combinational outputs are 0 while all m_valid are 0.
- Request-to-grant latency is 0 cycles: m_ready rises in the same cycle as m_valid when the master wins.
- Read data and m_rvalid appear exactly 1 cycle after the accepting edge.
- Throughput is one access per cycle; there are no bubbles when switching masters.
- Reset mid-burst clears burst and rvalid state immediately. A read accepted in the cycle before reset produces no m_rvalid.
- Simultaneous events:
  - A write and another master's read can never coincide; only one access is issued per cycle.
  - The same master may issue a read in cycle n and a write in cycle n+1. Its m_rvalid in n+1 still reflects the read.

## Structure
- Shared package slurm16_mem_pkg holds:
  - NUM_MASTERS default.
  - Master index constants: MASTER_CPU=0, MASTER_GFX=1, MASTER_AUDIO=2, MASTER_SPARE=3.
  - Width constants for BITS, ADDRESS_BITS and the 2-bit mask.
- One sub-module: slurm16_rr_select.
  - Combinational rotating-priority one-hot selector.
  - Inputs: request vector and start index.
  - Outputs: one-hot grant and its encoded index.
- Everything else (muxing, burst counter, rvalid pipeline) lives in the top module.

## Test plan
- Single read: master 0 reads 0x1234 with mem_data_in=0xBEEF returned the next cycle -> m_ready[0] in the request cycle, mem_address=0x1234, mem_en=1, mem_wr=0; next cycle m_rvalid=0001 and m_data_in=0xBEEF.
- Contention from reset: masters 0 and 2 valid continuously, MAX_BURST=4 -> grants 0,0,0,0,2,2,2,2,0,...; exactly one m_ready bit per cycle.
- Burst release: master 1 streams alone for 6 cycles -> granted all 6, burst_cnt saturates at 4. Master 3 raises valid at cycle 6 -> master 3 granted at cycle 6.
- Masked write: master 2 writes 0xAA55 to 0x8000 with mask 2'b10 -> mem_wr=1, mem_wr_mask=10, mem_data_out=0xAA55; no m_rvalid the next cycle.
- All four valid, MAX_BURST=1 -> grant order 0,1,2,3,0,1; each read's m_rvalid bit matches the previous cycle's grant.
- Reset mid-operation: RSTb low the cycle after master 1's read grant -> m_rvalid=0 immediately. After release with masters 1 and 3 valid -> master 1 granted first (owner reset to 3).
